mem_subsystem: RTL

Memory and I/O stage driven by the CPU's data-memory port (`mem_we`, `mem_addr`, `mem_in`, `mem_out`). The block decodes the CPU's 8-bit word address into three regions:
- a 240-word RAM;
- memory-mapped registers for a buffered TX stream and a single-entry RX stream, both with valid/ready handshakes to the outside world;
- an optional free-running cycle timer.

Reads are combinational so the CPU sees data in the same cycle. All state updates happen on the rising edge of `clk`.

---
 rtl/mem_subsystem.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_subsystem.sv
// CPU data-memory stage: 240-word RAM, buffered TX stream, single-entry RX stream.
// Optional free-running cycle timer at 0xF4/0xF5 when MEM_TIMER_EN is defined.
module mem_subsystem #(
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_we,
  input  logic [7:0]  mem_addr,
  input  logic [15:0] mem_in,
  output logic [15:0] mem_out,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  localparam int DATA_W    = 16;
  localparam int RAM_WORDS = 240;
  localparam int AW        = $clog2(TX_DEPTH);
  localparam logic [AW:0] TX_FULL_CNT = (AW+1)'(TX_DEPTH);

  localparam logic [7:0] A_TXDATA = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF1;
  localparam logic [7:0] A_RXDATA = 8'hF2;
  localparam logic [7:0] A_TMR_LO = 8'hF4;
  localparam logic [7:0] A_TMR_HI = 8'hF5;

  logic [DATA_W-1:0] ram    [0:RAM_WORDS-1];
  logic [DATA_W-1:0] tx_buf [0:TX_DEPTH-1];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       tx_cnt;
  logic              tx_ovf, rx_ovf, rx_full;
  logic [DATA_W-1:0] rx_hold;

  logic ram_sel, wr_tx, wr_status, wr_rx, tx_full, tx_empty, push_ok, pop, capture;

  assign ram_sel   = (mem_addr < 8'(RAM_WORDS));
  assign wr_tx     = mem_we && (mem_addr == A_TXDATA);
  assign wr_status = mem_we && (mem_addr == A_STATUS);
  assign wr_rx     = mem_we && (mem_addr == A_RXDATA);
  assign tx_full   = (tx_cnt == TX_FULL_CNT);
  assign tx_empty  = (tx_cnt == '0);
  assign push_ok   = wr_tx && !tx_full;
  assign pop       = !tx_empty && tx_ready;
  assign capture   = rx_valid && !rx_full;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_buf[rd_ptr];
  assign rx_ready = !rx_full;

  // Storage arrays carry no reset; reset still blocks same-cycle writes.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we && ram_sel) ram[mem_addr] <= mem_in;
    if (rst_n && push_ok) tx_buf[wr_ptr] <= mem_in;
    if (rst_n && capture) rx_hold <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      tx_cnt  <= '0;
      tx_ovf  <= 1'b0;
      rx_ovf  <= 1'b0;
      rx_full <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
      // A push into a full FIFO is dropped even when a pop frees a slot this edge.
      if (wr_tx && tx_full)             tx_ovf <= 1'b1;
      else if (wr_status && mem_in[3])  tx_ovf <= 1'b0;
      if (wr_rx)        rx_full <= 1'b0;
      else if (capture) rx_full <= 1'b1;
      if (rx_valid && rx_full && !wr_rx) rx_ovf <= 1'b1;
      else if (wr_status && mem_in[4])   rx_ovf <= 1'b0;
    end
  end

`ifdef MEM_TIMER_EN
  logic [31:0] timer, snap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
      snap  <= '0;
    end else begin
      timer <= (mem_we && (mem_addr == A_TMR_LO)) ? 32'd0 : timer + 32'd1;
      if (mem_we && (mem_addr == A_TMR_HI)) snap <= timer;
    end
  end
`endif

  always_comb begin
    mem_out = '0;
    if (ram_sel) begin
      mem_out = ram[mem_addr];
    end else begin
      case (mem_addr)
        A_STATUS: mem_out = {11'd0, rx_ovf, tx_ovf, rx_full, tx_empty, tx_full};
        A_RXDATA: mem_out = rx_full ? rx_hold : '0;
`ifdef MEM_TIMER_EN
        A_TMR_LO: mem_out = snap[15:0];
        A_TMR_HI: mem_out = snap[31:16];
`endif
        default:  mem_out = '0;
      endcase
    end
  end
endmodule
